// File: rtl/mux2x1_sel_arb.sv
// Round-robin arbiter driving the select of a 2:1 mux; all outputs come straight from flops.
// Optional hold-timeout enabled by defining MUX_SEL_ARB_TIMEOUT_EN.
module mux2x1_sel_arb #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic done,
  output logic select,
  output logic grant1,
  output logic grant2,
  output logic busy,
  output logic timeout
);

  // One-hot grant encoding so grant1/grant2 are direct flop outputs.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_G1   = 2'b01,
    S_G2   = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_last2;       // 1 when requester 2 was served last
  logic   w_last2_next;
  logic   r_select;
  logic   r_busy;
  logic   w_own_req;

  function automatic state_t pick(input logic a, input logic b, input logic last2);
    if (a && b) return last2 ? S_G1 : S_G2;
    else if (a) return S_G1;
    else if (b) return S_G2;
    else        return S_IDLE;
  endfunction

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_timeout_next;
`endif

  assign w_own_req = (r_state == S_G2) ? req2 : req1;

  always_comb begin
    w_state_next = r_state;
    w_last2_next = r_last2;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
    w_timeout_next = 1'b0;
`endif
    case (r_state)
      S_IDLE: w_state_next = pick(req1, req2, r_last2);
      S_G1, S_G2: begin
        // Priority: done, then abort, then forced release.
        if (done) begin
          w_last2_next = (r_state == S_G2);
          w_state_next = pick(req1, req2, r_state == S_G2);
        end else if (!w_own_req) begin
          w_last2_next = (r_state == S_G2);
          w_state_next = S_IDLE;
        end
`ifdef MUX_SEL_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(MAX_HOLD - 1)) begin
          w_last2_next   = (r_state == S_G2);
          w_state_next   = S_IDLE;
          w_timeout_next = 1'b1;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last2  <= 1'b1;
      r_select <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_last2 <= w_last2_next;
      r_busy  <= (w_state_next != S_IDLE);
      if (w_state_next == S_G1)
        r_select <= 1'b0;
      else if (w_state_next == S_G2)
        r_select <= 1'b1;
    end
  end

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  // Counter restarts on every fresh grant, including a done-driven re-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_next;
      if (w_state_next != S_IDLE && (w_state_next != r_state || done))
        r_cnt <= '0;
      else if (w_state_next != S_IDLE)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign grant1 = r_state[0];
  assign grant2 = r_state[1];
  assign busy   = r_busy;
  assign select = r_select;

endmodule
